// File: rtl/load_pkg.sv
// load_pkg: shared definitions for the load unit.
//   - Width codes for req_opt[1:0], using the same coding as the store path.
//   - Bit indices of the sign bit for byte and half fields.
//   - FSM state type.
//   - is_spanning(): reports whether an access crosses a word boundary.
package load_pkg;

    localparam logic [1:0] LD_W = 2'b00;
    localparam logic [1:0] LD_B = 2'b01;
    localparam logic [1:0] LD_H = 2'b10;

    localparam int unsigned BYTE_MSB = 7;
    localparam int unsigned HALF_MSB = 15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_RESP
    } load_state_e;

    // Width code 2'b11 is normalised to LD_W before this function is called.
    function automatic logic is_spanning(input logic [1:0] width, input logic [1:0] off);
        return ((width == LD_W) && (off != 2'd0)) ||
               ((width == LD_H) && (off == 2'd3));
    endfunction

endpackage

// File: rtl/load_extract.sv
// load_extract: combinational field extraction and extension.
// Ports:
//   dword_i [63:0]  {w1, w0}; w0 holds the addressed word
//   off_i   [1:0]   byte offset, taken from addr[1:0]
//   opt_i   [2:0]   [1:0] width code; [2]=1 zero-extends (ignored for word)
//   data_o  [31:0]  extended load data
module load_extract
    import load_pkg::*;
(
    input  logic [63:0] dword_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  opt_i,
    output logic [31:0] data_o
);

    logic [31:0] sh;
    logic        sgn_en;

    always_comb begin
        sh     = 32'(dword_i >> {off_i, 3'b000});
        sgn_en = ~opt_i[2];
        unique case (opt_i[1:0])
            LD_B:    data_o = {{24{sgn_en & sh[BYTE_MSB]}}, sh[BYTE_MSB:0]};
            LD_H:    data_o = {{16{sgn_en & sh[HALF_MSB]}}, sh[HALF_MSB:0]};
            default: data_o = sh;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// load_unit: MEM-stage load path placed in front of an asynchronous-read word RAM.
// The unit accepts a load request, reads one word (or two words when the access
// spans a word boundary), then extracts and extends the addressed field and
// returns the result through a valid/ready response.
// Ports:
//   clock, reset            rising-edge clock; asynchronous active-high reset
//   req_valid/req_ready     request handshake; req_ready is high only in IDLE
//   req_addr/req_opt/req_pc byte address, {zero-ext, width[1:0]}, PC of the load
//   mem_widx/mem_rdata      RAM word index (registered) and combinational read data
//   rsp_valid/rsp_ready     response handshake
//   rsp_data/rsp_pc/rsp_err load result, PC of the load, misaligned-access reject flag
// Configuration: when LOAD_MISALIGN_EN is defined, spanning loads read two words.
// When it is undefined, spanning loads are rejected with rsp_err=1 and rsp_data=0.
module load_unit
    import load_pkg::*;
#(
    parameter int unsigned MEM_AW = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [2:0]        req_opt,
    input  logic [31:0]       req_pc,
    output logic [MEM_AW-1:0] mem_widx,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [31:0]       rsp_pc,
    output logic              rsp_err
);

    load_state_e         state_q, state_d;
    logic [MEM_AW+1:0]   addr_q, addr_d;
    logic [2:0]          opt_q, opt_d;
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         w0_q, w0_d;
    logic [MEM_AW-1:0]   widx_q, widx_d;
    logic [31:0]         data_q, data_d;
    logic                err_q, err_d;

    logic [63:0]         ext_in;
    logic [31:0]         ext_data;
    logic                span;

    // Address bits above the RAM window do not affect the access.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:MEM_AW+2];

    // RD0 and non-spanning accesses see only the current word. RD1 pairs the
    // second word with the first word that was captured in RD0.
    assign ext_in = (state_q == ST_RD1) ? {mem_rdata, w0_q} : {32'h0, mem_rdata};
    assign span   = is_spanning(opt_q[1:0], addr_q[1:0]);

    load_extract u_extract (
        .dword_i (ext_in),
        .off_i   (addr_q[1:0]),
        .opt_i   (opt_q),
        .data_o  (ext_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            opt_q   <= '0;
            pc_q    <= '0;
            w0_q    <= '0;
            widx_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            opt_q   <= opt_d;
            pc_q    <= pc_d;
            w0_q    <= w0_d;
            widx_q  <= widx_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        opt_d     = opt_q;
        pc_d      = pc_q;
        w0_d      = w0_q;
        widx_d    = widx_q;
        data_d    = data_q;
        err_d     = err_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr[MEM_AW+1:0];
                    opt_d   = {req_opt[2], (req_opt[1:0] == 2'b11) ? LD_W : req_opt[1:0]};
                    pc_d    = req_pc;
                    // Index is registered here so the RAM output is valid throughout RD0.
                    widx_d  = req_addr[MEM_AW+1:2];
                    state_d = ST_RD0;
                end
            end
            ST_RD0: begin
                if (span) begin
`ifdef LOAD_MISALIGN_EN
                    w0_d    = mem_rdata;
                    widx_d  = widx_q + MEM_AW'(1);
                    state_d = ST_RD1;
`else
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
`endif
                end else begin
                    data_d  = ext_data;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RD1: begin
                data_d  = ext_data;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_widx = widx_q;
    assign rsp_data = data_q;
    assign rsp_err  = err_q;
    assign rsp_pc   = pc_q;

endmodule
